data_memory_lsu: RTL and testbench
==================================

// Module: data_memory_lsu
// PURPOSE
//  Byte-addressable data memory with built-in RISC-V load/store formatting, for the next core revision.
//  Supports LB/LH/LW/LBU/LHU and SB/SH/SW through byte-lane strobes.
//  Uses a valid/ready request handshake, a one-cycle response pulse, and a configurable load latency.
//  Flags misaligned and out-of-range accesses instead of silently wrapping.
//  Sits between the execute stage and a word array of DMEM_SIZE words.
// PARAMETERS
//  XLEN          32     data width; only 32 is supported
//  DMEM_SIZE     1024   depth in XLEN-bit words; must be a power of 2
//  READ_LATENCY  1      accept-to-response cycles for loads; legal range 1..4
//  INIT_FILE     ""     if non-empty, $readmemh preload of the word array
// PORTS
//  clk           in   1     rising-edge clock
//  rst_ni        in   1     asynchronous, active-low reset
//  req_valid     in   1     request present
//  req_ready     out  1     block can accept a request this cycle
//  req_addr      in   XLEN  byte address
//  req_we        in   1     1 = store, 0 = load
//  req_size      in   2     00 = byte, 01 = half, 10 = word, 11 = illegal
//  req_unsigned  in   1     loads only: 1 = zero-extend, 0 = sign-extend
//  req_wdata     in   XLEN  store data, right-aligned (bits [7:0] / [15:0] / [31:0])
//  rsp_valid     out  1     one-cycle response pulse
//  rsp_rdata     out  XLEN  extended load data; 0 for stores and errors
//  rsp_err       out  1     misaligned, out-of-range, or illegal size; qualified by rsp_valid
// BEHAVIOUR
//  Reset
//   - rst_ni low: state=IDLE, latency counter=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, req_ready=1.
//   - Memory array contents are not affected by reset.
//   - Reset mid-operation drops the pending response; no rsp_valid is issued for it.
//  Handshake
//   - A request is accepted on a rising edge where req_valid & req_ready.
//   - Exactly one rsp_valid pulse follows each accepted request, in order.
//   - rsp has no backpressure.
//  Addressing
//   - Word index = req_addr[$clog2(DMEM_SIZE)+1:2]; byte lane = req_addr[1:0].
//  Error (evaluated at accept)
//   - size=11; half with addr[0]=1; word with addr[1:0]!=0; any req_addr bit above
//     [$clog2(DMEM_SIZE)+1] set.
//   - On error: no write; response after 1 cycle with rsp_err=1, rsp_rdata=0.
//  Stores
//   - Array written on the accept edge.
//   - Byte strobes: SB = 1<<lane; SH = 0011<<lane; SW = 1111.
//   - Data is replicated across lanes before masking.
//   - Response after 1 cycle: rsp_err=0, rsp_rdata=0.
//  Loads
//   - Word is read on the accept edge into a pipeline register (snapshot).
//   - The lane is then selected and extended per size/unsigned.
//   - A load accepted the cycle after a store to the same word returns the stored data.
//   - Response READ_LATENCY cycles after the accept edge.
//  FSM
//   - IDLE: ready=1. On accept: error/store/(load with LAT=1) -> RESP;
//     load with LAT>1 -> WAIT, cnt=LAT-2.
//   - WAIT: ready=0. cnt!=0 -> cnt-- and stay; cnt=0 -> RESP.
//   - RESP: rsp_valid=1, ready=1. An accept in RESP branches exactly as from IDLE; else -> IDLE.
//   - Result: back-to-back accepts give one response per cycle when LAT=1.
//   - With LAT=N, ready is low for N-1 cycles after each load accept.
//  Outputs
//   - rsp_rdata and rsp_err are registered; they hold their value when rsp_valid=0.
// TESTING
//  1. SW 0xDEADBEEF @0x10, then LW @0x10 -> rsp_rdata=DEADBEEF, err=0; each rsp_valid 1 cycle after accept.
//  2. SW 0 @0x20; SB 0x80 @0x23 -> LB @0x23 = FFFFFF80, LBU = 00000080, LW @0x20 = 80000000.
//  3. SH 0x8001 @0x42 -> LH @0x42 = FFFF8001, LHU = 00008001, LW @0x40 = 80010000 (low half unchanged).
//  4. LW @0x11, LH @0x13, size=11, addr=4*DMEM_SIZE -> each rsp_err=1, rdata=0.
//     A following LW @0x10 still reads DEADBEEF (no write occurred).
//  5. READ_LATENCY=3, req_valid held high for 2 loads -> ready low 2 cycles after each accept.
//     Responses 3 cycles after each accept, in order.
//  6. Assert rst_ni low in WAIT (LAT=3) -> rsp_valid never pulses for that load, ready=1 after release.
//     Memory data previously written is still readable.
//  7. Full sweep: write 1024 words, then read all back -> every word matches; error count 0.

Source files
------------

// File: rtl/data_memory_lsu.sv
// data_memory_lsu
//   Byte-addressable data memory with RISC-V load/store formatting
//   (LB/LH/LW/LBU/LHU, SB/SH/SW). A request is accepted on req_valid & req_ready.
//   Each accepted request gets exactly one rsp_valid pulse, and responses come back in order.
//   Errors and stores respond one cycle after accept.
//   Loads respond READ_LATENCY cycles after accept.
//   Misaligned, out-of-range and illegal-size requests set rsp_err and do not write the array.
//
// Ports
//   clk, rst_ni            clock, asynchronous active-low reset
//   req_valid/req_ready    request handshake
//   req_addr, req_we       byte address, 1 = store
//   req_size, req_unsigned 00 byte / 01 half / 10 word; zero-extend loads when set
//   req_wdata              right-aligned store data
//   rsp_valid              one-cycle response pulse
//   rsp_rdata, rsp_err     registered response payload, held between pulses
module data_memory_lsu #(
    parameter int XLEN         = 32,
    parameter int DMEM_SIZE    = 1024,
    parameter int READ_LATENCY = 1,
    parameter     INIT_FILE    = ""
) (
    input  logic            clk,
    input  logic            rst_ni,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [XLEN-1:0] req_addr,
    input  logic            req_we,
    input  logic [1:0]      req_size,
    input  logic            req_unsigned,
    input  logic [XLEN-1:0] req_wdata,
    output logic            rsp_valid,
    output logic [XLEN-1:0] rsp_rdata,
    output logic            rsp_err
);
    localparam int AW = $clog2(DMEM_SIZE);
    // WAIT holds for LAT-2 extra cycles before moving to RESP.
    localparam logic [1:0] CNT_INIT = (READ_LATENCY > 1) ? 2'(READ_LATENCY - 2) : 2'd0;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

    logic [XLEN-1:0] mem_q [DMEM_SIZE];

    state_e          state_q;
    logic [1:0]      cnt_q;
    logic [XLEN-1:0] load_q;
    logic            rsp_valid_q;
    logic [XLEN-1:0] rsp_rdata_q;
    logic            rsp_err_q;

    logic [AW-1:0]   idx;
    logic [1:0]      lane;
    logic            oor, misal, req_err, accept, wr_en;
    logic [3:0]      strb;
    logic [XLEN-1:0] wdata_rep, ld_fmt;

    assign idx  = req_addr[AW+1:2];
    assign lane = req_addr[1:0];
    // Any address bit above the array range is an error rather than a wrap.
    assign oor  = |(req_addr >> (AW + 2));

    always_comb begin
        misal     = 1'b0;
        strb      = 4'b0000;
        wdata_rep = req_wdata;
        case (req_size)
            2'b00: begin
                strb      = 4'b0001 << lane;
                wdata_rep = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                misal     = lane[0];
                strb      = 4'b0011 << lane;
                wdata_rep = {2{req_wdata[15:0]}};
            end
            2'b10: begin
                misal = |lane;
                strb  = 4'b1111;
            end
            default: misal = 1'b1;
        endcase
    end

    assign req_err   = misal | oor;
    assign req_ready = (state_q != WAIT);
    assign accept    = req_valid & req_ready;
    assign wr_en     = accept & req_we & ~req_err;

    // Lane select and sign/zero extension of the word read at accept.
    always_comb begin
        logic [XLEN-1:0] sh;
        sh = mem_q[idx] >> {lane, 3'b000};
        case (req_size)
            2'b00:   ld_fmt = req_unsigned ? {24'b0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
            2'b01:   ld_fmt = req_unsigned ? {16'b0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            default: ld_fmt = sh;
        endcase
    end

    // Array has no reset; contents survive rst_ni.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (strb[b]) mem_q[idx][8*b +: 8] <= wdata_rep[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            cnt_q       <= 2'd0;
            load_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            rsp_valid_q <= 1'b0;
            case (state_q)
                WAIT: begin
                    if (cnt_q != 2'd0) begin
                        cnt_q <= cnt_q - 2'd1;
                    end else begin
                        state_q     <= RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= load_q;
                        rsp_err_q   <= 1'b0;
                    end
                end
                default: begin
                    // IDLE and RESP accept identically, giving one response per cycle at LAT=1.
                    if (accept) begin
                        if (req_err || req_we || READ_LATENCY == 1) begin
                            state_q     <= RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= req_err;
                            rsp_rdata_q <= (req_err || req_we) ? '0 : ld_fmt;
                        end else begin
                            state_q <= WAIT;
                            cnt_q   <= CNT_INIT;
                            load_q  <= ld_fmt;
                        end
                    end else begin
                        state_q <= IDLE;
                    end
                end
            endcase
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_data_memory_lsu.sv
module tb_data_memory_lsu;
    logic        clk = 1'b0;
    logic        rst_ni;
    logic        v1, rdy1, we1, un1, rv1, re1;
    logic [1:0]  sz1;
    logic [31:0] a1, wd1, rd1;
    logic        v3, rdy3, we3, un3, rv3, re3;
    logic [1:0]  sz3;
    logic [31:0] a3, wd3, rd3;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int st;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          due;
    } exp_t;
    exp_t q1[$];
    exp_t q3[$];

    always #5 clk = ~clk;

    data_memory_lsu #(.XLEN(32), .DMEM_SIZE(1024), .READ_LATENCY(1), .INIT_FILE("")) u1 (
        .clk(clk), .rst_ni(rst_ni), .req_valid(v1), .req_ready(rdy1), .req_addr(a1),
        .req_we(we1), .req_size(sz1), .req_unsigned(un1), .req_wdata(wd1),
        .rsp_valid(rv1), .rsp_rdata(rd1), .rsp_err(re1));

    data_memory_lsu #(.XLEN(32), .DMEM_SIZE(1024), .READ_LATENCY(3), .INIT_FILE("")) u3 (
        .clk(clk), .rst_ni(rst_ni), .req_valid(v3), .req_ready(rdy3), .req_addr(a3),
        .req_we(we3), .req_size(sz3), .req_unsigned(un3), .req_wdata(wd3),
        .rsp_valid(rv3), .rsp_rdata(rd3), .rsp_err(re3));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp_v, cyc);
        end
    endtask

    // Compare a DUT's response port against the head of its scoreboard queue.
    task automatic scan(input int d, input logic v, input logic [31:0] rd, input logic e);
        exp_t x;
        bit   have;
        have = 1'b0;
        if (d == 0 && q1.size() > 0) begin have = 1'b1; x = q1[0]; end
        if (d == 1 && q3.size() > 0) begin have = 1'b1; x = q3[0]; end
        if (v) begin
            if (!have) chk($sformatf("dut%0d_spurious_rsp", d), 32'd1, 32'd0);
            else begin
                if (d == 0) void'(q1.pop_front()); else void'(q3.pop_front());
                chk($sformatf("dut%0d_rdata", d), rd, x.rdata);
                chk($sformatf("dut%0d_err", d), 32'(e), 32'(x.err));
                chk($sformatf("dut%0d_latency", d), 32'(cyc), 32'(x.due));
            end
        end else if (have && x.due <= cyc) begin
            if (d == 0) void'(q1.pop_front()); else void'(q3.pop_front());
            chk($sformatf("dut%0d_missing_rsp", d), 32'd0, 32'd1);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        scan(0, rv1, rd1, re1);
        scan(1, rv3, rd3, re3);
    endtask

    // Present a request, wait (bounded) for ready, push the expectation, take the accept edge.
    // valid stays high afterwards so consecutive calls hold req_valid asserted.
    task automatic req(input int d, input bit we, input logic [1:0] sz, input bit un,
                       input logic [31:0] a, input logic [31:0] wd, input logic [31:0] er,
                       input bit ee, input bit push, output int stall);
        exp_t x;
        int   lat;
        if (d == 0) begin v1 = 1; we1 = we; sz1 = sz; un1 = un; a1 = a; wd1 = wd; end
        else        begin v3 = 1; we3 = we; sz3 = sz; un3 = un; a3 = a; wd3 = wd; end
        stall = 0;
        while (!((d == 0) ? rdy1 : rdy3) && stall < 16) begin
            tick();
            stall++;
        end
        if (!((d == 0) ? rdy1 : rdy3)) begin
            chk($sformatf("dut%0d_ready_timeout", d), 32'd0, 32'd1);
        end else begin
            lat     = (we || ee || d == 0) ? 1 : 3;
            x.rdata = er;
            x.err   = ee;
            x.due   = cyc + lat;
            if (push) begin
                if (d == 0) q1.push_back(x); else q3.push_back(x);
            end
            tick();
        end
    endtask

    task automatic idle();
        v1 = 0;
        v3 = 0;
    endtask

    initial begin
        rst_ni = 0;
        v1 = 0; we1 = 0; sz1 = 0; un1 = 0; a1 = 0; wd1 = 0;
        v3 = 0; we3 = 0; sz3 = 0; un3 = 0; a3 = 0; wd3 = 0;
        tick();
        tick();
        chk("rst_ready1", 32'(rdy1), 32'd1);
        chk("rst_valid1", 32'(rv1), 32'd0);
        chk("rst_rdata1", rd1, 32'd0);
        chk("rst_err1", 32'(re1), 32'd0);
        chk("rst_ready3", 32'(rdy3), 32'd1);
        chk("rst_valid3", 32'(rv3), 32'd0);
        rst_ni = 1;
        tick();

        // Word store then load.
        req(0, 1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 32'h0, 0, 1, st);
        req(0, 0, 2'b10, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0, 1, st);
        idle();
        tick();
        chk("rdata_hold", rd1, 32'hDEADBEEF);

        // Byte store with replication/masking, then signed/unsigned byte loads.
        req(0, 1, 2'b10, 0, 32'h20, 32'h0, 32'h0, 0, 1, st);
        req(0, 1, 2'b00, 0, 32'h23, 32'hAAAAAA80, 32'h0, 0, 1, st);
        req(0, 0, 2'b00, 0, 32'h23, 32'h0, 32'hFFFFFF80, 0, 1, st);
        req(0, 0, 2'b00, 1, 32'h23, 32'h0, 32'h00000080, 0, 1, st);
        req(0, 0, 2'b10, 0, 32'h20, 32'h0, 32'h80000000, 0, 1, st);

        // Upper half store leaves lower half intact.
        req(0, 1, 2'b10, 0, 32'h40, 32'h0, 32'h0, 0, 1, st);
        req(0, 1, 2'b01, 0, 32'h42, 32'h55558001, 32'h0, 0, 1, st);
        req(0, 0, 2'b01, 0, 32'h42, 32'h0, 32'hFFFF8001, 0, 1, st);
        req(0, 0, 2'b01, 1, 32'h42, 32'h0, 32'h00008001, 0, 1, st);
        req(0, 0, 2'b10, 0, 32'h40, 32'h0, 32'h80010000, 0, 1, st);

        // Error cases; erroneous stores must not write (including out-of-range aliasing onto 0x10).
        req(0, 0, 2'b10, 0, 32'h11, 32'h0, 32'h0, 1, 1, st);
        req(0, 0, 2'b01, 0, 32'h13, 32'h0, 32'h0, 1, 1, st);
        req(0, 0, 2'b11, 0, 32'h10, 32'h0, 32'h0, 1, 1, st);
        req(0, 0, 2'b10, 0, 32'h1000, 32'h0, 32'h0, 1, 1, st);
        req(0, 1, 2'b10, 0, 32'h11, 32'h0, 32'h0, 1, 1, st);
        req(0, 1, 2'b10, 0, 32'h1010, 32'h12345678, 32'h0, 1, 1, st);
        req(0, 0, 2'b10, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0, 1, st);
        idle();
        tick();

        // LAT=3: stores respond in one cycle, loads in three with ready low two cycles.
        req(1, 1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 32'h0, 0, 1, st);
        req(1, 1, 2'b10, 0, 32'h14, 32'h11111111, 32'h0, 0, 1, st);
        req(1, 0, 2'b10, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0, 1, st);
        chk("lat3_first_stall", 32'(st), 32'd0);
        req(1, 0, 2'b10, 0, 32'h14, 32'h0, 32'h11111111, 0, 1, st);
        chk("lat3_stall_a", 32'(st), 32'd2);
        req(1, 0, 2'b00, 0, 32'h17, 32'h0, 32'h00000011, 0, 1, st);
        chk("lat3_stall_b", 32'(st), 32'd2);
        idle();
        repeat (4) tick();

        // Reset while in WAIT: the pending load must never respond.
        req(1, 0, 2'b10, 0, 32'h14, 32'h0, 32'h0, 0, 0, st);
        idle();
        chk("wait_ready_low", 32'(rdy3), 32'd0);
        rst_ni = 0;
        #1;
        chk("midrst_ready", 32'(rdy3), 32'd1);
        chk("midrst_valid", 32'(rv3), 32'd0);
        tick();
        rst_ni = 1;
        repeat (4) tick();
        chk("postrst_ready", 32'(rdy3), 32'd1);
        req(1, 0, 2'b10, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0, 1, st);
        idle();
        repeat (4) tick();

        // Full sweep on the LAT=1 instance.
        for (int i = 0; i < 1024; i++)
            req(0, 1, 2'b10, 0, 32'(i) << 2, {16'(i), ~16'(i)}, 32'h0, 0, 1, st);
        for (int i = 0; i < 1024; i++)
            req(0, 0, 2'b10, 0, 32'(i) << 2, 32'h0, {16'(i), ~16'(i)}, 0, 1, st);
        idle();
        repeat (3) tick();

        chk("q1_drained", 32'(q1.size()), 32'd0);
        chk("q3_drained", 32'(q3.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
